// File: rtl/bus_dev_port_if.sv
// Shared-bus side of one device port: the TX head offered to the bus and the
// deliveries coming back from it.
interface bus_dev_port_if #(
  parameter int pckg_sz = 16
);
  logic               pndng;
  logic [pckg_sz-1:0] D_pop;
  logic               pop;
  logic               push;
  logic [pckg_sz-1:0] D_push;

  modport master (
    input  pndng,
    input  D_pop,
    output pop,
    output push,
    output D_push
  );

  modport slave (
    output pndng,
    output D_pop,
    input  pop,
    input  push,
    input  D_push
  );
endinterface

// File: rtl/bus_dev_port.sv
// Per-device bus port: FWFT TX queue toward the bus, address-filtered FWFT RX
// queue toward the host.
module bus_dev_port #(
  parameter int         pckg_sz    = 16,
  parameter int         fifo_depth = 16,
  parameter logic [7:0] id         = 8'h00,
  parameter logic [7:0] broadcast  = 8'hFF
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            host_wr,
  input  logic [pckg_sz-1:0]              host_wr_data,
  output logic                            tx_full,
  output logic [$clog2(fifo_depth+1)-1:0] tx_count,
  output logic                            tx_overflow,
  output logic                            pop_underflow,
  bus_dev_port_if.slave                   bus,
  output logic                            rx_valid,
  output logic [pckg_sz-1:0]              rx_data,
  input  logic                            rx_rd,
  output logic [$clog2(fifo_depth+1)-1:0] rx_count,
  output logic                            rx_overflow,
  output logic [7:0]                      filt_drops
);
  localparam int aw = $clog2(fifo_depth);
  localparam int cw = $clog2(fifo_depth+1);
  localparam logic [cw-1:0] full_cnt = cw'(fifo_depth);

  logic [pckg_sz-1:0] tx_mem [fifo_depth];
  logic [pckg_sz-1:0] rx_mem [fifo_depth];

  logic [aw-1:0] tx_rd_q, tx_rd_d, tx_wr_q, tx_wr_d;
  logic [aw-1:0] rx_rd_q, rx_rd_d, rx_wr_q, rx_wr_d;
  logic [cw-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic          tx_ovf_q, tx_ovf_d, pop_unf_q, pop_unf_d, rx_ovf_q, rx_ovf_d;
  logic [7:0]    filt_q, filt_d;

  logic tx_do_wr, tx_do_rd, rx_acc, rx_do_wr, rx_do_rd;

  always_comb begin
    // A read on a full queue frees the slot the same-edge write lands in.
    tx_do_rd  = bus.pop && (tx_cnt_q != '0);
    tx_do_wr  = host_wr && ((tx_cnt_q != full_cnt) || tx_do_rd);
    tx_rd_d   = tx_do_rd ? tx_rd_q + aw'(1) : tx_rd_q;
    tx_wr_d   = tx_do_wr ? tx_wr_q + aw'(1) : tx_wr_q;
    tx_cnt_d  = tx_cnt_q;
    case ({tx_do_wr, tx_do_rd})
      2'b10:   tx_cnt_d = tx_cnt_q + cw'(1);
      2'b01:   tx_cnt_d = tx_cnt_q - cw'(1);
      default: tx_cnt_d = tx_cnt_q;
    endcase
    tx_ovf_d  = tx_ovf_q | (host_wr & ~tx_do_wr);
    pop_unf_d = pop_unf_q | (bus.pop & (tx_cnt_q == '0));

    rx_acc   = bus.push && ((bus.D_push[pckg_sz-1 -: 8] == id) ||
                            (bus.D_push[pckg_sz-1 -: 8] == broadcast));
    rx_do_rd = rx_rd && (rx_cnt_q != '0);
    rx_do_wr = rx_acc && ((rx_cnt_q != full_cnt) || rx_do_rd);
    rx_rd_d  = rx_do_rd ? rx_rd_q + aw'(1) : rx_rd_q;
    rx_wr_d  = rx_do_wr ? rx_wr_q + aw'(1) : rx_wr_q;
    rx_cnt_d = rx_cnt_q;
    case ({rx_do_wr, rx_do_rd})
      2'b10:   rx_cnt_d = rx_cnt_q + cw'(1);
      2'b01:   rx_cnt_d = rx_cnt_q - cw'(1);
      default: rx_cnt_d = rx_cnt_q;
    endcase
    rx_ovf_d = rx_ovf_q | (rx_acc & ~rx_do_wr);
    filt_d   = (bus.push && !rx_acc && (filt_q != 8'hFF)) ? filt_q + 8'd1 : filt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_rd_q   <= '0;
      tx_wr_q   <= '0;
      tx_cnt_q  <= '0;
      tx_ovf_q  <= 1'b0;
      pop_unf_q <= 1'b0;
      rx_rd_q   <= '0;
      rx_wr_q   <= '0;
      rx_cnt_q  <= '0;
      rx_ovf_q  <= 1'b0;
      filt_q    <= '0;
    end else begin
      tx_rd_q   <= tx_rd_d;
      tx_wr_q   <= tx_wr_d;
      tx_cnt_q  <= tx_cnt_d;
      tx_ovf_q  <= tx_ovf_d;
      pop_unf_q <= pop_unf_d;
      rx_rd_q   <= rx_rd_d;
      rx_wr_q   <= rx_wr_d;
      rx_cnt_q  <= rx_cnt_d;
      rx_ovf_q  <= rx_ovf_d;
      filt_q    <= filt_d;
    end
  end

  // Storage needs no reset: stale entries are unreachable once the counts clear.
  always_ff @(posedge clk) begin
    if (!reset && tx_do_wr) tx_mem[tx_wr_q] <= host_wr_data;
    if (!reset && rx_do_wr) rx_mem[rx_wr_q] <= bus.D_push;
  end

  assign bus.pndng     = (tx_cnt_q != '0);
  assign bus.D_pop     = tx_mem[tx_rd_q];
  assign tx_full       = (tx_cnt_q == full_cnt);
  assign tx_count      = tx_cnt_q;
  assign tx_overflow   = tx_ovf_q;
  assign pop_underflow = pop_unf_q;
  assign rx_valid      = (rx_cnt_q != '0);
  assign rx_data       = rx_mem[rx_rd_q];
  assign rx_count      = rx_cnt_q;
  assign rx_overflow   = rx_ovf_q;
  assign filt_drops    = filt_q;
endmodule

// File: tb/tb_bus_dev_port.sv
// Bench for bus_dev_port: queue-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_bus_dev_port;
  localparam int         depth = 16;
  localparam logic [7:0] my_id = 8'h03;

  logic        clk = 1'b0;
  logic        reset, host_wr, rx_rd;
  logic [15:0] host_wr_data;
  logic        tx_full, tx_overflow, pop_underflow, rx_valid, rx_overflow;
  logic [4:0]  tx_count, rx_count;
  logic [15:0] rx_data;
  logic [7:0]  filt_drops;

  bus_dev_port_if #(.pckg_sz(16)) bus_if ();

  bus_dev_port #(.pckg_sz(16), .fifo_depth(depth), .id(my_id), .broadcast(8'hFF)) dut (
    .clk(clk), .reset(reset), .host_wr(host_wr), .host_wr_data(host_wr_data),
    .tx_full(tx_full), .tx_count(tx_count), .tx_overflow(tx_overflow),
    .pop_underflow(pop_underflow), .bus(bus_if.slave), .rx_valid(rx_valid),
    .rx_data(rx_data), .rx_rd(rx_rd), .rx_count(rx_count),
    .rx_overflow(rx_overflow), .filt_drops(filt_drops)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  logic [15:0] m_tx[$];
  logic [15:0] m_rx[$];
  bit          m_txo, m_unf, m_rxo;
  int          m_drops;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: queues of packets updated from the inputs applied this edge.
  task automatic model_update();
    bit acc, rd_ok, pop_ok;
    if (reset) begin
      m_tx.delete(); m_rx.delete();
      m_txo = 0; m_unf = 0; m_rxo = 0; m_drops = 0;
      return;
    end
    pop_ok = bus_if.pop && (m_tx.size() > 0);
    if (bus_if.pop && m_tx.size() == 0) m_unf = 1;
    if (pop_ok) void'(m_tx.pop_front());
    if (host_wr) begin
      if (m_tx.size() < depth) m_tx.push_back(host_wr_data);
      else m_txo = 1;
    end
    acc = bus_if.push && (bus_if.D_push[15:8] == my_id || bus_if.D_push[15:8] == 8'hFF);
    if (bus_if.push && !acc && m_drops < 255) m_drops++;
    rd_ok = rx_rd && (m_rx.size() > 0);
    if (rd_ok) void'(m_rx.pop_front());
    if (acc) begin
      if (m_rx.size() < depth) m_rx.push_back(bus_if.D_push);
      else m_rxo = 1;
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("pndng", bus_if.pndng, m_tx.size() != 0);
      chk("tx_count", tx_count, m_tx.size());
      chk("tx_full", tx_full, m_tx.size() == depth);
      chk("tx_overflow", tx_overflow, m_txo);
      chk("pop_underflow", pop_underflow, m_unf);
      if (m_tx.size() != 0) chk("D_pop", bus_if.D_pop, m_tx[0]);
      chk("rx_valid", rx_valid, m_rx.size() != 0);
      chk("rx_count", rx_count, m_rx.size());
      chk("rx_overflow", rx_overflow, m_rxo);
      if (m_rx.size() != 0) chk("rx_data", rx_data, m_rx[0]);
      chk("filt_drops", filt_drops, m_drops);
    end
  end

  task automatic step(input logic rst, input logic wr, input logic [15:0] wd,
                      input logic p, input logic ps, input logic [15:0] pd,
                      input logic rd);
    @(negedge clk);
    reset = rst; host_wr = wr; host_wr_data = wd;
    bus_if.pop = p; bus_if.push = ps; bus_if.D_push = pd; rx_rd = rd;
    @(posedge clk);
    model_update();
    #2;
  endtask

  task automatic idle();
    step(0, 0, 16'h0, 0, 0, 16'h0, 0);
  endtask

  initial begin
    reset = 1; host_wr = 0; host_wr_data = '0; rx_rd = 0;
    bus_if.pop = 0; bus_if.push = 0; bus_if.D_push = '0;
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    chk_en = 1'b1;
    chk("lit_rst_pndng", bus_if.pndng, 0);
    chk("lit_rst_rx_valid", rx_valid, 0);
    chk("lit_rst_tx_full", tx_full, 0);

    // Single packet latency and drain
    step(0, 1, 16'h02AB, 0, 0, 0, 0);
    chk("lit_pndng1", bus_if.pndng, 1);
    chk("lit_dpop1", bus_if.D_pop, 16'h02AB);
    chk("lit_txcnt1", tx_count, 1);
    step(0, 0, 0, 1, 0, 0, 0);
    chk("lit_pndng0", bus_if.pndng, 0);
    chk("lit_txcnt0", tx_count, 0);

    // Fill, overflow, drain across pointer wrap
    for (int i = 0; i < 16; i++) step(0, 1, 16'h0100 + 16'(i), 0, 0, 0, 0);
    chk("lit_txfull", tx_full, 1);
    chk("lit_txcnt16", tx_count, 16);
    step(0, 1, 16'h0110, 0, 0, 0, 0);
    chk("lit_txovf", tx_overflow, 1);
    chk("lit_txcnt16b", tx_count, 16);
    for (int i = 0; i < 16; i++) begin
      chk("lit_dpop_seq", bus_if.D_pop, 16'h0100 + i);
      step(0, 0, 0, 1, 0, 0, 0);
    end

    // Same-edge write and pop while full
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 1, 16'h0200 + 16'(i), 0, 0, 0, 0);
    step(0, 1, 16'h0A55, 1, 0, 0, 0);
    chk("lit_full_wp_cnt", tx_count, 16);
    chk("lit_full_wp_ovf", tx_overflow, 0);
    for (int i = 0; i < 15; i++) step(0, 0, 0, 1, 0, 0, 0);
    chk("lit_last_0a55", bus_if.D_pop, 16'h0A55);
    step(0, 0, 0, 1, 0, 0, 0);

    // Address filter
    step(0, 0, 0, 0, 1, 16'h0311, 0);
    step(0, 0, 0, 0, 1, 16'hFF22, 0);
    step(0, 0, 0, 0, 1, 16'h0433, 0);
    chk("lit_rxcnt2", rx_count, 2);
    chk("lit_rx0311", rx_data, 16'h0311);
    chk("lit_filt1", filt_drops, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("lit_rxff22", rx_data, 16'hFF22);

    // Underflow, RX overflow, reset clears everything
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    chk("lit_unf", pop_underflow, 1);
    chk("lit_unf_cnt", tx_count, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 17; i++) step(0, 0, 0, 0, 1, 16'h0300 + 16'(i), 0);
    chk("lit_rxovf", rx_overflow, 1);
    chk("lit_rxcnt16", rx_count, 16);
    step(0, 1, 16'h0301, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("lit_rst_rxcnt", rx_count, 0);
    chk("lit_rst_txcnt", tx_count, 0);
    chk("lit_rst_flags", {tx_overflow, pop_underflow, rx_overflow}, 0);
    chk("lit_rst_valid", {bus_if.pndng, rx_valid}, 0);

    // Drop counter saturation
    for (int i = 0; i < 300; i++) step(0, 0, 0, 0, 1, 16'h0700 + 16'(i & 255), 0);
    chk("lit_filt255", filt_drops, 255);
    chk("lit_filt_rx0", rx_count, 0);

    // Randomized traffic, alternating fill-biased and drain-biased phases
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4000; i++) begin
      int pw, pr;
      logic [7:0]  dst;
      logic [15:0] pd;
      pw = ((i / 200) % 2 == 0) ? 75 : 25;
      pr = 100 - pw;
      case ($urandom_range(0, 2))
        0:       dst = my_id;
        1:       dst = 8'hFF;
        default: dst = 8'($urandom);
      endcase
      pd = {dst, 8'($urandom)};
      step($urandom_range(0, 499) == 0,
           $urandom_range(0, 99) < pw, 16'($urandom),
           $urandom_range(0, 99) < pr,
           $urandom_range(0, 99) < pw, pd,
           $urandom_range(0, 99) < pr);
    end
    idle();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
